// File: rtl/shape_raster.sv
// shape_raster: rasterizes a line, rectangle outline or midpoint circle into a clipped
// valid/ready pixel stream. Define SHAPE_RASTER_FILL_EN to add the fill input (solid rect/circle).
module shape_raster #(
    parameter int H_RES = 160,
    parameter int V_RES = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [7:0] point_a_x,
    input  logic [7:0] point_a_y,
    input  logic [7:0] point_b_x,
    input  logic [7:0] point_b_y,
    input  logic       shape_trigger,
`ifdef SHAPE_RASTER_FILL_EN
    input  logic       fill,
`endif
    input  logic       pix_ready,
    output logic       pix_valid,
    output logic [7:0] pix_x,
    output logic [7:0] pix_y,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, SETUP, LINE, RECT, CIRC, FIN} state_t;
    state_t state_reg, state_next;

    localparam logic signed [9:0] H_LIM = 10'(H_RES);
    localparam logic signed [9:0] V_LIM = 10'(V_RES);

    function automatic logic signed [11:0] ext(input logic signed [9:0] v);
        return {{2{v[9]}}, v};
    endfunction

    logic [1:0]         mode_reg;
    logic [7:0]         ax_reg, ay_reg, bx_reg, by_reg;
    logic               fill_on;
    logic signed [9:0]  dx_reg, dy_reg, r_reg;
    logic signed [9:0]  xmin_reg, xmax_reg, ymin_reg, ymax_reg;
    logic               sx_neg_reg, sy_neg_reg;
    logic signed [9:0]  cur_x_reg, cur_y_reg, gx_reg, gy_reg;
    logic signed [11:0] err_reg;
    logic [2:0]         oct_reg;
    logic [1:0]         span_reg;

    logic signed [9:0]  ax_s, ay_s, bx_s, by_s, dx_c, dy_c, r_c;
    logic signed [9:0]  xmin_c, xmax_c, ymin_c, ymax_c;
    assign ax_s   = $signed({2'b00, ax_reg});
    assign ay_s   = $signed({2'b00, ay_reg});
    assign bx_s   = $signed({2'b00, bx_reg});
    assign by_s   = $signed({2'b00, by_reg});
    assign dx_c   = (bx_s >= ax_s) ? bx_s - ax_s : ax_s - bx_s;
    assign dy_c   = (by_s >= ay_s) ? by_s - ay_s : ay_s - by_s;
    assign r_c    = (dx_c >= dy_c) ? dx_c : dy_c;
    assign xmin_c = (ax_s <= bx_s) ? ax_s : bx_s;
    assign xmax_c = (ax_s <= bx_s) ? bx_s : ax_s;
    assign ymin_c = (ay_s <= by_s) ? ay_s : by_s;
    assign ymax_c = (ay_s <= by_s) ? by_s : ay_s;

    // Bresenham step decisions from e2 = 2*err
    logic signed [11:0] e2;
    logic               step_x, step_y;
    assign e2     = err_reg <<< 1;
    assign step_x = e2 > -ext(dy_reg);
    assign step_y = e2 < ext(dx_reg);

    // Midpoint circle: octant values for the following iteration
    logic signed [9:0]  ny, nx;
    logic signed [11:0] nerr;
    assign ny   = gy_reg + 10'sd1;
    assign nx   = err_reg[11] ? gx_reg : gx_reg - 10'sd1;
    assign nerr = err_reg[11] ? err_reg + (ext(ny) <<< 1) + 12'sd1
                              : err_reg + ((ext(ny) - ext(nx)) <<< 1) + 12'sd1;

    logic signed [9:0] cand_x, cand_y, span_hi, span_row, next_lo;
    logic [2:0]        span_nx;
    always_comb begin
        span_hi  = ax_s + gx_reg;
        span_row = ay_s + gy_reg;
        case (span_reg)
            2'd0:    span_nx = (gy_reg != 10'sd0) ? 3'd1 : ((gx_reg != gy_reg) ? 3'd2 : 3'd4);
            2'd1:    span_nx = (gx_reg != gy_reg) ? 3'd2 : 3'd4;
            2'd2:    span_nx = 3'd3;
            default: span_nx = 3'd4;
        endcase
        case (span_reg)
            2'd1: span_row = ay_s - gy_reg;
            2'd2: begin span_row = ay_s + gx_reg; span_hi = ax_s + gy_reg; end
            2'd3: begin span_row = ay_s - gx_reg; span_hi = ax_s + gy_reg; end
            default: ;
        endcase
        next_lo = (span_nx >= 3'd2) ? ax_s - gy_reg : ax_s - gx_reg;
        cand_x  = cur_x_reg;
        cand_y  = cur_y_reg;
        if (state_reg == CIRC) begin
            if (fill_on) begin
                cand_y = span_row;
            end else begin
                case (oct_reg)
                    3'd0: begin cand_x = ax_s + gx_reg; cand_y = ay_s + gy_reg; end
                    3'd1: begin cand_x = ax_s + gy_reg; cand_y = ay_s + gx_reg; end
                    3'd2: begin cand_x = ax_s - gy_reg; cand_y = ay_s + gx_reg; end
                    3'd3: begin cand_x = ax_s - gx_reg; cand_y = ay_s + gy_reg; end
                    3'd4: begin cand_x = ax_s - gx_reg; cand_y = ay_s - gy_reg; end
                    3'd5: begin cand_x = ax_s - gy_reg; cand_y = ay_s - gx_reg; end
                    3'd6: begin cand_x = ax_s + gy_reg; cand_y = ay_s - gx_reg; end
                    default: begin cand_x = ax_s + gx_reg; cand_y = ay_s - gy_reg; end
                endcase
            end
        end
    end

    logic shape_st, in_range, advance, iter_end, last;
    assign shape_st = (state_reg == LINE) || (state_reg == RECT) || (state_reg == CIRC);
    assign in_range = (cand_x >= 10'sd0) && (cand_x < H_LIM) && (cand_y >= 10'sd0) && (cand_y < V_LIM);
    assign advance  = shape_st && (!in_range || pix_ready);
    assign iter_end = fill_on ? ((cur_x_reg >= span_hi) && (span_nx == 3'd4))
                              : ((oct_reg == 3'd7) || (r_reg == 10'sd0));
    always_comb begin
        case (state_reg)
            LINE:    last = (cur_x_reg == bx_s) && (cur_y_reg == by_s);
            RECT:    last = (cur_x_reg == xmax_reg) && (cur_y_reg == ymax_reg);
            CIRC:    last = iter_end && ((r_reg == 10'sd0) || (ny > nx));
            default: last = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (shape_trigger && mode != 2'd0) state_next = SETUP;
            SETUP: state_next = (mode_reg == 2'd1) ? RECT : ((mode_reg == 2'd2) ? CIRC : LINE);
            LINE, RECT, CIRC: if (advance && last) state_next = FIN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pix_valid = 1'b0;
        pix_x     = 8'd0;
        pix_y     = 8'd0;
        busy      = (state_reg != IDLE) && (state_reg != FIN);
        done      = (state_reg == FIN);
        if (shape_st) begin
            pix_valid = in_range;
            pix_x     = cand_x[7:0];
            pix_y     = cand_y[7:0];
        end
    end

`ifdef SHAPE_RASTER_FILL_EN
    logic fill_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                                 fill_reg <= 1'b0;
        else if (state_reg == IDLE && shape_trigger && mode != 2'd0) fill_reg <= fill;
    end
    assign fill_on = fill_reg;
`else
    assign fill_on = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg <= 2'd0;
            ax_reg <= 8'd0; ay_reg <= 8'd0; bx_reg <= 8'd0; by_reg <= 8'd0;
            dx_reg <= 10'sd0; dy_reg <= 10'sd0; r_reg <= 10'sd0;
            xmin_reg <= 10'sd0; xmax_reg <= 10'sd0; ymin_reg <= 10'sd0; ymax_reg <= 10'sd0;
            sx_neg_reg <= 1'b0; sy_neg_reg <= 1'b0;
            cur_x_reg <= 10'sd0; cur_y_reg <= 10'sd0; gx_reg <= 10'sd0; gy_reg <= 10'sd0;
            err_reg <= 12'sd0; oct_reg <= 3'd0; span_reg <= 2'd0;
        end else begin
            case (state_reg)
                IDLE: if (shape_trigger && mode != 2'd0) begin
                    mode_reg <= mode;
                    ax_reg <= point_a_x; ay_reg <= point_a_y;
                    bx_reg <= point_b_x; by_reg <= point_b_y;
                end
                SETUP: begin
                    dx_reg <= dx_c; dy_reg <= dy_c; r_reg <= r_c;
                    sx_neg_reg <= bx_s < ax_s; sy_neg_reg <= by_s < ay_s;
                    xmin_reg <= xmin_c; xmax_reg <= xmax_c; ymin_reg <= ymin_c; ymax_reg <= ymax_c;
                    gx_reg <= r_c; gy_reg <= 10'sd0; oct_reg <= 3'd0; span_reg <= 2'd0;
                    case (mode_reg)
                        2'd1:    begin cur_x_reg <= xmin_c; cur_y_reg <= ymin_c; err_reg <= 12'sd0; end
                        2'd2:    begin cur_x_reg <= ax_s - r_c; cur_y_reg <= ay_s; err_reg <= 12'sd1 - ext(r_c); end
                        default: begin cur_x_reg <= ax_s; cur_y_reg <= ay_s; err_reg <= ext(dx_c) - ext(dy_c); end
                    endcase
                end
                LINE: if (advance) begin
                    if (step_x) cur_x_reg <= sx_neg_reg ? cur_x_reg - 10'sd1 : cur_x_reg + 10'sd1;
                    if (step_y) cur_y_reg <= sy_neg_reg ? cur_y_reg - 10'sd1 : cur_y_reg + 10'sd1;
                    err_reg <= err_reg - (step_x ? ext(dy_reg) : 12'sd0) + (step_y ? ext(dx_reg) : 12'sd0);
                end
                RECT: if (advance) begin
                    if (cur_x_reg == xmax_reg) begin
                        cur_x_reg <= xmin_reg;
                        cur_y_reg <= cur_y_reg + 10'sd1;
                    end else if (fill_on || cur_y_reg == ymin_reg || cur_y_reg == ymax_reg) begin
                        cur_x_reg <= cur_x_reg + 10'sd1;
                    end else begin
                        cur_x_reg <= xmax_reg;  // interior row: jump from left edge to right edge
                    end
                end
                CIRC: if (advance) begin
                    if (fill_on && cur_x_reg < span_hi) begin
                        cur_x_reg <= cur_x_reg + 10'sd1;
                    end else if (fill_on && span_nx != 3'd4) begin
                        span_reg  <= span_nx[1:0];
                        cur_x_reg <= next_lo;
                    end else if (iter_end) begin
                        oct_reg <= 3'd0; span_reg <= 2'd0;
                        gx_reg <= nx; gy_reg <= ny; err_reg <= nerr;
                        cur_x_reg <= ax_s - nx;
                    end else begin
                        oct_reg <= oct_reg + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/shape_raster.md
Name: shape_raster

Overview:
- Downstream of the draw-mode controller.
- Takes the latched point A / point B pair and the mode when the controller pulses shape_trigger, then rasterizes a line, rectangle outline or circle.
- Emits the shape as a stream of pixel coordinates over a valid/ready handshake to the framebuffer write port.
- Freehand mode (0) is not handled here.

Parameters:
- H_RES, 160, horizontal resolution; pixels with x >= H_RES are clipped.
- V_RES, 120, vertical resolution; pixels with y >= V_RES are clipped.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- mode  input  2  shape select: 1=rect, 2=circle, 3=line, 0=ignored
- point_a_x  input  8  point A x (line start / rect corner / circle centre)
- point_a_y  input  8  point A y
- point_b_x  input  8  point B x (line end / opposite rect corner / circle radius point)
- point_b_y  input  8  point B y
- shape_trigger  input  1  one-cycle start pulse
- pix_ready  input  1  framebuffer accepts pixel
- pix_valid  output  1  pixel coordinate valid
- pix_x  output  8  pixel x
- pix_y  output  8  pixel y
- busy  output  1  rasterization in progress
- done  output  1  one-cycle pulse after last pixel accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: pix_valid=0, pix_x=0, pix_y=0, busy=0, done=0; state=IDLE.
- FSM states: IDLE, SETUP, LINE, RECT, CIRC, FIN.
- IDLE:
  - shape_trigger=1 with mode!=0: latch mode, A and B; busy=1 next cycle; go to SETUP.
  - mode=0: trigger ignored.
- Trigger while busy: ignored, no effect on the shape in progress.
- SETUP: one cycle. Computes:
  - dx=|bx-ax|, dy=|by-ay|, step signs;
  - xmin/xmax/ymin/ymax;
  - r=max(dx,dy).
  - Then enters LINE, RECT or CIRC.
  - First candidate pixel is presented 2 cycles after the trigger cycle.
- Internal arithmetic: 10-bit signed; candidates may be negative (circle only).
- Clipping: a candidate with x<0, y<0, x>=H_RES or y>=V_RES is skipped. It takes 1 cycle with pix_valid=0, and generation advances.
- Handshake:
  - A transfer occurs on pix_valid && pix_ready.
  - While pix_valid=1 and pix_ready=0, pix_x/pix_y are held stable.
  - The generator does not advance until the transfer.
  - pix_valid never drops without a transfer (except on reset).
  - After a transfer, the next in-range pixel may be valid the following cycle, giving 1 pixel/cycle with pix_ready tied high.
- LINE: Bresenham, A to B inclusive.
  - Emits exactly max(dx,dy)+1 pixels.
  - Major axis advances by one every pixel.
  - Error term: err=dx-dy, standard e2=2*err update.
  - A==B gives a single pixel.
- RECT: rows ymin..ymax in ascending order.
  - Rows ymin and ymax: all x from xmin..xmax, ascending.
  - Other rows: xmin, then xmax (xmax only if xmax!=xmin).
  - No duplicate pixels; a degenerate rectangle (a line or a point) emits each pixel once.
- CIRC: midpoint algorithm, centre A, radius r.
  - Start: x=r, y=0, err=1-r.
  - Each iteration emits 8 points in this fixed order: (cx+x,cy+y), (cx+y,cy+x), (cx-y,cy+x), (cx-x,cy+y), (cx-x,cy-y), (cx-y,cy-x), (cx+y,cy-x), (cx+x,cy-y).
  - Duplicates are emitted as generated.
  - Iterations continue while y<=x.
  - r=0: single pixel at the centre.
- FIN: one cycle; done=1, busy=0 in that same cycle; return to IDLE. A trigger in the FIN cycle is ignored.
- A shape with every pixel clipped still completes and pulses done.
- Reset mid-shape: immediate abort, all outputs to reset values, no done.

Optional Feature:
- Macro: SHAPE_RASTER_FILL_EN.
- Defined:
  - Adds input port fill (1 bit), latched at trigger.
  - Rect with fill=1: every row emits all x from xmin..xmax, ascending.
  - Circle with fill=1: each iteration emits horizontal spans instead of the 8 points, in row order cy+y, cy-y, cy+x, cy-x. A row is skipped if it was already emitted (y=0 or y=x cases).
- Undefined: fill port absent; outline-only behaviour as specified above.

Test Plan:
- Line A(2,3) B(6,5), pix_ready=1 -> 5 pixels: (2,3),(3,3),(4,4),(5,4),(6,5); done one cycle after last transfer; busy low in the done cycle.
- Rect A(12,12) B(10,10) -> 8 pixels in order (10,10),(11,10),(12,10),(10,11),(12,11),(10,12),(11,12),(12,12).
- Circle A(0,0) B(2,1) (r=2) -> only non-negative points transferred; busy time exceeds transfer count; done still pulses.
- Line A(0,0) B(3,0) with pix_ready toggling 1,0,0,1,... -> pix_x/pix_y stable while stalled; exactly 4 transfers (0..3,0); no lost or repeated pixels.
- Second trigger mid-line, and a trigger with mode=0 in IDLE -> both ignored; pixel sequence of the first shape is unchanged.
- Reset asserted after the 2nd transfer of a rect -> pix_valid, busy, done = 0 immediately; no done; a new trigger after reset runs cleanly.
